// File: rtl/inport_unit.sv
// inport_unit: input-port front end of the CPU datapath.
// A device pushes words through a valid/ready handshake into a small FIFO.
// The FIFO head is presented on BusMuxInInport. Each rising edge of the
// INPORTout level consumes one word.
// Optional feature macro: INPORT_OVERFLOW_EN adds the sticky overflow flag
// inport_ovf and the saturating drop counter inport_drop_cnt.
module inport_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] dev_data,
    input  logic             dev_valid,
    output logic             dev_ready,
    input  logic             INPORTout,
    output logic [WIDTH-1:0] BusMuxInInport,
    output logic [CNTW-1:0]  inport_count,
`ifdef INPORT_OVERFLOW_EN
    output logic             inport_ovf,
    output logic [7:0]       inport_drop_cnt,
`endif
    output logic             inport_empty
);

    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] last_word_q, last_word_d;
    logic             inport_q, inport_d;

    logic full;
    logic empty;
    logic push;
    logic pop_req;
    logic pop;

    // Status and handshake decode; full/empty come from the registered count only.
    always_comb begin
        full      = (count_q == CNTW'(DEPTH));
        empty     = (count_q == '0);
        dev_ready = !full;
        push      = dev_valid && !full && Reset_n;
        pop_req   = INPORTout && !inport_q;
        pop       = pop_req && !empty && Reset_n;
    end

    // Bus output: head entry while words are held, otherwise the last consumed word.
    always_comb begin
        BusMuxInInport = empty ? last_word_q : mem_q[rd_ptr_q];
        inport_count   = count_q;
        inport_empty   = empty;
    end

    // Storage write on push.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = dev_data;
        end
    end

    // Next-state for pointers, occupancy, last_word and the INPORTout delay.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        last_word_d = last_word_q;
        inport_d    = INPORTout;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            last_word_d = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTRW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            last_word_q <= '0;
            inport_q    <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            last_word_q <= last_word_d;
            inport_q    <= inport_d;
        end
    end

`ifdef INPORT_OVERFLOW_EN
    logic       ovf_q, ovf_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Overflow tracking: a word offered while full is counted as dropped.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (dev_valid && full) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // Overflow registers, cleared only by reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Expose overflow state.
    always_comb begin
        inport_ovf      = ovf_q;
        inport_drop_cnt = drop_cnt_q;
    end
`endif

endmodule

// File: tb/tb_inport_unit.sv
// Directed self-checking bench for inport_unit.
module tb_inport_unit;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] dev_data;
    logic        dev_valid;
    logic        dev_ready;
    logic        INPORTout;
    logic [31:0] BusMuxInInport;
    logic [2:0]  inport_count;
    logic        inport_empty;
`ifdef INPORT_OVERFLOW_EN
    logic        inport_ovf;
    logic [7:0]  inport_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    inport_unit #(.WIDTH(32), .DEPTH(4), .CNTW(3)) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .dev_data       (dev_data),
        .dev_valid      (dev_valid),
        .dev_ready      (dev_ready),
        .INPORTout      (INPORTout),
        .BusMuxInInport (BusMuxInInport),
        .inport_count   (inport_count),
`ifdef INPORT_OVERFLOW_EN
        .inport_ovf     (inport_ovf),
        .inport_drop_cnt(inport_drop_cnt),
`endif
        .inport_empty   (inport_empty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        dev_valid = 1'b1;
        dev_data  = d;
        step();
        dev_valid = 1'b0;
    endtask

    // One INPORTout pulse followed by a low cycle; returns the bus value during the pulse.
    task automatic pop_pulse(output logic [31:0] seen);
        INPORTout = 1'b1;
        #1;
        seen = BusMuxInInport;
        step();
        INPORTout = 1'b0;
        step();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        dev_valid = 1'b1;
        dev_data  = 32'hDEAD;
        step();
        step();
        dev_valid = 1'b0;
        Reset_n   = 1'b1;
        #1;
        checks++;
        if (inport_count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", inport_count);
        end
        checks++;
        if (inport_empty !== 1'b1) begin
            errors++; $display("FAIL reset_empty: got %b expected 1", inport_empty);
        end
        checks++;
        if (dev_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", dev_ready);
        end
        checks++;
        if (BusMuxInInport !== 32'd0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0", BusMuxInInport);
        end
    endtask

    task automatic test_single();
        logic [31:0] seen;
        push_word(32'd18);
        checks++;
        if (BusMuxInInport !== 32'd18) begin
            errors++; $display("FAIL single_fallthrough: got %0d expected 18", BusMuxInInport);
        end
        checks++;
        if (inport_count !== 3'd1) begin
            errors++; $display("FAIL single_count: got %0d expected 1", inport_count);
        end
        pop_pulse(seen);
        checks++;
        if (seen !== 32'd18) begin
            errors++; $display("FAIL single_read: got %0d expected 18", seen);
        end
        checks++;
        if (inport_empty !== 1'b1) begin
            errors++; $display("FAIL single_empty_after: got %b expected 1", inport_empty);
        end
        checks++;
        if (BusMuxInInport !== 32'd18) begin
            errors++; $display("FAIL single_last_word: got %0d expected 18", BusMuxInInport);
        end
    endtask

    task automatic test_fill();
        logic [31:0] seen;
        for (int i = 1; i <= 4; i++) begin
            push_word(32'(i));
        end
        checks++;
        if (inport_count !== 3'd4) begin
            errors++; $display("FAIL fill_count: got %0d expected 4", inport_count);
        end
        checks++;
        if (dev_ready !== 1'b0) begin
            errors++; $display("FAIL fill_ready: got %b expected 0", dev_ready);
        end
        push_word(32'd5);
        checks++;
        if (inport_count !== 3'd4) begin
            errors++; $display("FAIL full_refuse_count: got %0d expected 4", inport_count);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_pulse(seen);
            checks++;
            if (seen !== 32'(i)) begin
                errors++; $display("FAIL fill_read%0d: got %0d expected %0d", i, seen, i);
            end
        end
        checks++;
        if (inport_empty !== 1'b1 || dev_ready !== 1'b1) begin
            errors++; $display("FAIL fill_drained: got empty=%b ready=%b expected 1 1", inport_empty, dev_ready);
        end
        push_word(32'd6);
        push_word(32'd7);
        pop_pulse(seen);
        checks++;
        if (seen !== 32'd6) begin
            errors++; $display("FAIL wrap_read6: got %0d expected 6", seen);
        end
        pop_pulse(seen);
        checks++;
        if (seen !== 32'd7) begin
            errors++; $display("FAIL wrap_read7: got %0d expected 7", seen);
        end
    endtask

    task automatic test_held();
        logic [31:0] seen;
        push_word(32'd10);
        push_word(32'd11);
        INPORTout = 1'b1;
        #1;
        checks++;
        if (BusMuxInInport !== 32'd10) begin
            errors++; $display("FAIL held_first: got %0d expected 10", BusMuxInInport);
        end
        step();
        step();
        step();
        checks++;
        if (inport_count !== 3'd1) begin
            errors++; $display("FAIL held_count_high: got %0d expected 1", inport_count);
        end
        INPORTout = 1'b0;
        step();
        checks++;
        if (inport_count !== 3'd1 || BusMuxInInport !== 32'd11) begin
            errors++; $display("FAIL held_after: got count=%0d bus=%0d expected 1 11", inport_count, BusMuxInInport);
        end
        pop_pulse(seen);
        checks++;
        if (seen !== 32'd11) begin
            errors++; $display("FAIL held_drain: got %0d expected 11", seen);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] seen;
        push_word(32'd20);
        push_word(32'd21);
        INPORTout = 1'b1;
        dev_valid = 1'b1;
        dev_data  = 32'd22;
        #1;
        checks++;
        if (BusMuxInInport !== 32'd20) begin
            errors++; $display("FAIL simul_read20: got %0d expected 20", BusMuxInInport);
        end
        step();
        INPORTout = 1'b0;
        dev_valid = 1'b0;
        checks++;
        if (inport_count !== 3'd2) begin
            errors++; $display("FAIL simul_count: got %0d expected 2", inport_count);
        end
        step();
        pop_pulse(seen);
        checks++;
        if (seen !== 32'd21) begin
            errors++; $display("FAIL simul_read21: got %0d expected 21", seen);
        end
        pop_pulse(seen);
        checks++;
        if (seen !== 32'd22) begin
            errors++; $display("FAIL simul_read22: got %0d expected 22", seen);
        end
    endtask

    task automatic test_empty_pop();
        logic [31:0] seen;
        pop_pulse(seen);
        checks++;
        if (seen !== 32'd22) begin
            errors++; $display("FAIL empty_pop_bus: got %0d expected 22", seen);
        end
        checks++;
        if (inport_count !== 3'd0 || inport_empty !== 1'b1) begin
            errors++; $display("FAIL empty_pop_state: got count=%0d empty=%b expected 0 1", inport_count, inport_empty);
        end
        push_word(32'd30);
        checks++;
        if (BusMuxInInport !== 32'd30 || inport_count !== 3'd1) begin
            errors++; $display("FAIL empty_pop_ptr: got bus=%0d count=%0d expected 30 1", BusMuxInInport, inport_count);
        end
        pop_pulse(seen);
    endtask

    task automatic test_midreset();
        push_word(32'd40);
        push_word(32'd41);
        do_reset();
        checks++;
        if (inport_count !== 3'd0 || BusMuxInInport !== 32'd0) begin
            errors++; $display("FAIL midreset: got count=%0d bus=%0d expected 0 0", inport_count, BusMuxInInport);
        end
    endtask

`ifdef INPORT_OVERFLOW_EN
    task automatic test_overflow();
        do_reset();
        checks++;
        if (inport_ovf !== 1'b0 || inport_drop_cnt !== 8'd0) begin
            errors++; $display("FAIL ovf_reset: got ovf=%b drop=%0d expected 0 0", inport_ovf, inport_drop_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            push_word(32'(50 + i));
        end
        checks++;
        if (inport_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_not_yet: got %b expected 0", inport_ovf);
        end
        dev_valid = 1'b1;
        dev_data  = 32'd99;
        step();
        step();
        step();
        dev_valid = 1'b0;
        checks++;
        if (inport_ovf !== 1'b1 || inport_drop_cnt !== 8'd3) begin
            errors++; $display("FAIL ovf_set: got ovf=%b drop=%0d expected 1 3", inport_ovf, inport_drop_cnt);
        end
        do_reset();
        checks++;
        if (inport_ovf !== 1'b0 || inport_drop_cnt !== 8'd0) begin
            errors++; $display("FAIL ovf_clear: got ovf=%b drop=%0d expected 0 0", inport_ovf, inport_drop_cnt);
        end
    endtask
`endif

    initial begin
        Reset_n   = 1'b0;
        dev_valid = 1'b0;
        dev_data  = '0;
        INPORTout = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_held();
        test_simultaneous();
        test_empty_pop();
        test_midreset();
`ifdef INPORT_OVERFLOW_EN
        test_overflow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
